// File: rtl/bloom_pkg.sv
// Shared types and constants for the Bloom filter engine and its index mux.
package bloom_pkg;

    localparam int HIT_CNT_W = 16;
    localparam int OP_W      = 2;

    typedef enum logic [OP_W-1:0] {
        OP_QUERY  = 2'd0,
        OP_INSERT = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } bloom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_RESP  = 2'd2
    } bloom_state_e;

endpackage

// File: rtl/bloom_idx_mux.sv
// Combinational pick of bit index j out of the latched packed index vector.
module bloom_idx_mux #(
    parameter int K     = 3,
    parameter int IDX_W = 8,
    parameter int CNT_W = 2
) (
    input  logic [K*IDX_W-1:0] idx_vec_i,
    input  logic [CNT_W-1:0]   sel_i,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        idx_o = idx_vec_i[IDX_W-1:0];
        for (int j = 1; j < K; j++) begin
            if (sel_i == CNT_W'(j)) begin
                idx_o = idx_vec_i[j*IDX_W +: IDX_W];
            end
        end
    end

endmodule

// File: rtl/bloom_filter_engine.sv
// Bloom filter engine: one-bit-per-cycle probe/insert over a BL_SIZE flop array.
// Optional statistics outputs (occupancy, hit_count) enabled by BLOOM_STATS_EN.
module bloom_filter_engine
    import bloom_pkg::*;
#(
    parameter int  BL_SIZE = 256,
    parameter int  K       = 3,
    localparam int IDX_W   = $clog2(BL_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_op,
    input  logic [K*IDX_W-1:0]   req_idx,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_match,
    output logic [OP_W-1:0]      rsp_op,
    output logic                 busy
`ifdef BLOOM_STATS_EN
    ,
    output logic [IDX_W:0]       occupancy,
    output logic [HIT_CNT_W-1:0] hit_count
`endif
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    bloom_state_e       state_q;
    bloom_op_e          op_q;
    logic [K*IDX_W-1:0] idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               match_q;
    logic [BL_SIZE-1:0] bits_q;
    logic               rsp_valid_q;
    logic               rsp_match_q;

    logic [IDX_W-1:0]   cur_idx;
    logic               cur_bit;
    logic               last_probe;

    bloom_idx_mux #(
        .K     (K),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_idx_mux (
        .idx_vec_i (idx_q),
        .sel_i     (cnt_q),
        .idx_o     (cur_idx)
    );

    // Probe reads the array before this cycle's insert write lands.
    assign cur_bit    = bits_q[cur_idx];
    assign last_probe = (cnt_q == CNT_W'(K - 1));

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_match = rsp_match_q;
    assign rsp_op    = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_QUERY;
            idx_q       <= '0;
            cnt_q       <= '0;
            match_q     <= 1'b0;
            bits_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_match_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= bloom_op_e'(req_op);
                        idx_q       <= req_idx;
                        cnt_q       <= '0;
                        match_q     <= 1'b1;
                        rsp_match_q <= 1'b0;
                        if (req_op == OP_QUERY || req_op == OP_INSERT) begin
                            state_q <= ST_PROBE;
                        end else begin
                            if (req_op == OP_CLEAR) begin
                                bits_q <= '0;
                            end
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_PROBE: begin
                    match_q <= match_q & cur_bit;
                    if (op_q == OP_INSERT) begin
                        bits_q[cur_idx] <= 1'b1;
                    end
                    if (last_probe) begin
                        rsp_valid_q <= 1'b1;
                        rsp_match_q <= match_q & cur_bit;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BLOOM_STATS_EN
    logic [IDX_W:0]       occ_q;
    logic [HIT_CNT_W-1:0] hit_q;

    assign occupancy = occ_q;
    assign hit_count = hit_q;

    // Occupancy tracks only 0->1 transitions so repeated inserts do not inflate it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
            hit_q <= '0;
        end else if (state_q == ST_IDLE && req_valid && req_op == OP_CLEAR) begin
            occ_q <= '0;
            hit_q <= '0;
        end else begin
            if (state_q == ST_PROBE && op_q == OP_INSERT && !cur_bit) begin
                occ_q <= occ_q + (IDX_W + 1)'(1);
            end
            if (state_q == ST_RESP && rsp_ready && op_q == OP_QUERY &&
                rsp_match_q && hit_q != '1) begin
                hit_q <= hit_q + HIT_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/bloom_filter_engine.md
BLOOM_FILTER_ENGINE -- requirements
Module: bloom_filter_engine

Interface
REQ-001 Parameter BL_SIZE, default 256: number of filter bits; power of two, 8..4096.
REQ-002 Parameter K, default 3: hash indices per request, 1..8.
REQ-003 Derived constant IDX_W = $clog2(BL_SIZE): index width.
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Port list:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  2  operation code.
- req_idx  in  K*IDX_W  K packed bit indices; index j occupies bits [j*IDX_W +: IDX_W].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_match  out  1  all K probed bits were set.
- rsp_op  out  2  echo of the accepted req_op.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 Internal filter array: BL_SIZE flops, all 0 after reset.
REQ-007 Opcodes: QUERY=0, INSERT=1, CLEAR=2, RSVD=3.
REQ-008 FSM states: IDLE, PROBE, RESP.
- req_ready = 1 only in IDLE.
REQ-009 IDLE with req_valid: latch op and idx.
- QUERY/INSERT -> PROBE, probe counter = 0.
- CLEAR/RSVD -> RESP.
REQ-010 PROBE, cycle j (j = 0..K-1):
- read bit idx[j] and AND it into a running match flag, initialised to 1 at accept.
- INSERT also sets bit idx[j] in the same cycle.
- after j = K-1 -> RESP.
REQ-011 Match semantics: the match flag reflects array state before that cycle's write.
- INSERT with duplicate indices: the duplicate probe sees the bit already set.
REQ-012 CLEAR zeroes the entire array in the accept cycle; rsp_match = 0.
REQ-013 RSVD: no array change, rsp_match = 0.
REQ-014 Latency from accept edge to rsp_valid high:
- K+1 cycles for QUERY/INSERT.
- 1 cycle for CLEAR/RSVD.
REQ-015 RESP holds rsp_valid, rsp_match and rsp_op stable until rsp_ready is sampled high, then -> IDLE.
- No same-cycle re-accept: req_ready rises the cycle after the handshake.
REQ-016 With rsp_ready tied high, sustained throughput is one request per K+2 cycles (QUERY/INSERT).
REQ-017 req_idx, req_op and req_valid changes after accept SHALL NOT affect the operation in flight.
REQ-018 rsp_valid, rsp_match and rsp_op SHALL be registered outputs.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- state IDLE, array all 0, probe counter 0.
- rsp_valid 0, rsp_match 0, rsp_op 0, busy 0.
- stats counters 0.
REQ-020 Reset asserted mid-PROBE or mid-RESP abandons the operation; no response is produced after release.

Configuration
REQ-021 Macro BLOOM_STATS_EN defined adds two outputs:
- occupancy [IDX_W:0]: count of set bits; +1 only on a 0->1 write; 0 on CLEAR.
- hit_count [15:0]: +1 on each QUERY response handshake with rsp_match = 1; saturates at 16'hFFFF; 0 on CLEAR.
REQ-022 Macro BLOOM_STATS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-023 Package bloom_pkg SHALL hold:
- the op enum (bloom_op_e), the state enum (bloom_state_e).
- the constants HIT_CNT_W = 16 and OP_W = 2.
REQ-024 One sub-module, bloom_idx_mux: combinational selection of idx[j] from the latched packed vector. All state stays in the top module.

Verification (BL_SIZE = 256, K = 3)
REQ-025 After reset, QUERY idx {5, 9, 200} -> rsp_match = 0 at accept + 4 cycles; occupancy = 0.
REQ-026 INSERT {5, 9, 200} then QUERY {200, 5, 9} -> INSERT match 0, QUERY match 1; occupancy = 3, hit_count = 1.
REQ-027 INSERT {7, 7, 7} on an empty array -> rsp_match = 0 (probe 0 sees 0); occupancy = 1.
REQ-028 Hold rsp_ready low for 10 cycles after QUERY -> rsp fields stable, req_ready = 0, req_idx changes ignored; req_ready = 1 the cycle after the handshake.
REQ-029 INSERT {1, 2, 3}, CLEAR, QUERY {1, 2, 3} -> CLEAR response after 1 cycle with match 0; final QUERY match 0; occupancy = 0, hit_count = 0.
REQ-030 Assert rst_n low in PROBE cycle 1 of INSERT {10, 11, 12}, then release -> no rsp_valid; a following QUERY {10, 11, 12} returns match 0.
